// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. It holds HI/LO and runs a fixed-latency busy window
// for mult/div. Results are combinational on the latched operands and written on the last cycle.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_ovf;
  logic signed [31:0] divisor_s;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] divisor_u, quot_u, rem_u;
  logic               is_md_start;

  always_comb begin
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    // Keep the divider away from /0 and the signed overflow case; those results are overridden.
    divisor_s = ((b_q == 32'd0) || div_ovf) ? 32'sd1 : $signed(b_q);
    divisor_u = (b_q == 32'd0) ? 32'd1 : b_q;
    quot_s    = $signed(a_q) / divisor_s;
    rem_s     = $signed(a_q) % divisor_s;
    if (div_ovf) begin
      quot_s = 32'sh8000_0000;
      rem_s  = 32'sd0;
    end
    quot_u = a_q / divisor_u;
    rem_u  = a_q % divisor_u;
  end

  assign is_md_start = start && (md_op >= OpMult) && (md_op <= OpDivu);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (!cancel) begin
          if (is_md_start) begin
            op_d    = md_op;
            a_d     = a;
            b_d     = b;
            cnt_d   = (md_op <= OpMultu) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            state_d = StRun;
          end else if (md_op == OpMthi) begin
            hi_d = a;
          end else if (md_op == OpMtlo) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          case (op_q)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpDiv: begin
              if (b_q != 32'd0) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OpDivu: begin
              if (b_q != 32'd0) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table for mult/div results and latency, plus
// hand-written sequences for mthi/mtlo, cancellation, reset mid-op and start re-pulse.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[9];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one md op, optionally pokes the inputs for one cycle during the busy window,
  // and returns the number of cycles busy was seen high (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, input logic [2:0] poke_op, input logic poke_cancel,
                        output int cycles);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (cycles == poke_at) begin
        start  = 1'b1;
        md_op  = poke_op;
        a      = 32'hAAAA_AAAA;
        b      = 32'h0000_0003;
        cancel = poke_cancel;
      end else begin
        start  = 1'b0;
        md_op  = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        cancel = 1'b0;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    md_op  = 3'd0;
    cancel = 1'b0;
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    cancel   = 1'b0;

    vecs[0] = '{"mult_m1x2",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{"multu_ffx2",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{"divu_by0",    3'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{"mult_max",    3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[6] = '{"div_7_m2",    3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7] = '{"mult_m3x4",   3'd1, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5};
    vecs[8] = '{"divu_100_7",  3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, 0, 3'd0, 1'b0, cyc);
      check32({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
      check32({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check32({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // mthi then mtlo on consecutive edges, no busy
    @(negedge clk);
    md_op = 3'd5;
    a     = 32'h1234_5678;
    @(negedge clk);
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd6;
    a     = 32'h9ABC_DEF0;
    @(negedge clk);
    check32("mtlo_lo", lo, 32'h9ABC_DEF0);
    check32("mtlo_hi_kept", hi, 32'h1234_5678);
    check32("mtlo_busy", {31'd0, busy}, 32'd0);
    md_op  = 3'd5;
    a      = 32'hDEAD_BEEF;
    cancel = 1'b1;
    @(negedge clk);
    check32("mthi_cancel_hi", hi, 32'h1234_5678);

    // start mult with cancel: ignored
    start = 1'b1;
    md_op = 3'd1;
    a     = 32'h0000_0003;
    b     = 32'h0000_0005;
    @(negedge clk);
    check32("start_cancel_busy", {31'd0, busy}, 32'd0);
    start  = 1'b0;
    md_op  = 3'd0;
    cancel = 1'b0;
    @(negedge clk);
    check32("start_cancel_busy2", {31'd0, busy}, 32'd0);
    check32("start_cancel_hi", hi, 32'h1234_5678);
    check32("start_cancel_lo", lo, 32'h9ABC_DEF0);

    // cancel (with mthi) on cycle 2 of a running div: div completes normally
    run_op(3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 2, 3'd5, 1'b1, cyc);
    check32("div_cancel_cycles", cyc, 10);
    check32("div_cancel_hi", hi, 32'h0000_0002);
    check32("div_cancel_lo", lo, 32'hFFFF_FFF2);

    // reset at cycle 3 of a running mult
    @(negedge clk);
    start = 1'b1;
    md_op = 3'd1;
    a     = 32'h0000_0005;
    b     = 32'h0000_0006;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    check32("rst_mid_busy_c1", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check32("rst_mid_busy_c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("rst_mid_busy", {31'd0, busy}, 32'd0);
    check32("rst_mid_hi", hi, 32'd0);
    check32("rst_mid_lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    check32("rst_mid_no_write_lo", lo, 32'd0);
    check32("rst_mid_no_write_busy", {31'd0, busy}, 32'd0);

    // divu 100/7 with a mult start re-pulsed mid-flight
    run_op(3'd4, 32'h0000_0064, 32'h0000_0007, 4, 3'd1, 1'b0, cyc);
    check32("repulse_cycles", cyc, 10);
    check32("repulse_hi", hi, 32'h0000_0002);
    check32("repulse_lo", lo, 32'h0000_000E);
    repeat (3) @(negedge clk);
    check32("repulse_idle_busy", {31'd0, busy}, 32'd0);
    check32("repulse_lo_kept", lo, 32'h0000_000E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- It is the producer side of the stall handshake: it accepts `start` plus an opcode from E and drives `start`/`busy` status back to the hazard controller.
- While `start` or `busy` is high, the hazard controller stalls D and lets E/M/W advance.
- Holds the architectural HI/LO registers and supports pipeline cancellation on exception or interrupt.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu; qualified by md_op.
- md_op  input  3  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; 0 and 7 are no-op.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- cancel  input  1  exception/interrupt flush this cycle; suppresses any E-stage md action.
- busy  output  1  operation in flight; also read by the hazard controller.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset:
  - One clock with reset=1 clears busy, hi, lo and the cycle counter to 0.
  - Reset mid-operation aborts the operation; no HI/LO write occurs.
  - reset has priority over every other input.
- State machine: IDLE, RUN.
- IDLE, start=1, md_op in 1..4, cancel=0:
  - latch a, b, md_op.
  - load counter with MULT_CYCLES or DIV_CYCLES.
  - go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with cancel=1: ignored; stay IDLE, busy stays 0.
- IDLE, start=1 with md_op outside 1..4: ignored.
- RUN:
  - counter decrements each cycle; busy=1 for exactly N cycles.
  - On the edge where the counter reaches its last cycle, write the result to HI/LO, clear busy and return to IDLE.
  - Example: start sampled at edge T, busy high for edges T+1..T+N, hi/lo valid after edge T+N, busy=0 after edge T+N.
- start during RUN: ignored. The controller never issues it; the unit must not restart or corrupt the in-flight op.
- cancel during RUN does not abort. The op was already committed when it left E, so it completes normally.
- mthi/mtlo (md_op 5/6):
  - writes a into hi/lo at the next edge; no busy.
  - Takes effect regardless of the start pin.
  - Suppressed if cancel=1 or state is RUN.
- Arithmetic:
  - mult: {hi,lo} = signed(a) * signed(b), full 64 bits.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Signed div overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (b=0): busy runs the full DIV_CYCLES; hi and lo are left unchanged.
- Result computation may be combinational on the latched operands. Only the write timing is cycle-accurate.
- hi/lo are plain register outputs. There is no internal forwarding; mfhi/mflo hazards are covered by the controller stalling on start||busy.

Test Plan:
1. Reset, then mult a=0xFFFFFFFF b=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy=0.
2. multu a=0xFFFFFFFF b=0x00000002 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
3. div a=0xFFFFFFF9 (-7) b=2 -> busy exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu 7/0 -> 10 busy cycles, hi/lo unchanged.
4. mthi a=0x12345678, next cycle mtlo a=0x9ABCDEF0 -> hi/lo update on the same edges, busy never asserts. mthi with cancel=1 -> hi unchanged.
5. Cancellation:
   - start mult with cancel=1 -> busy stays 0, hi/lo unchanged.
   - cancel=1 asserted on cycle 2 of a running div -> div completes on schedule with the correct result.
6. Reset at cycle 3 of a running mult -> next cycle busy=0, hi=lo=0. Then start divu 100/7 -> lo=14, hi=2 after 10 busy cycles. start re-pulsed during busy -> ignored, result unchanged.
